// File: rtl/iiitb_bm_pkg.sv
// Shared definitions for the radix-2 Booth multiplier sequencer slice.
package iiitb_bm_pkg;

    localparam int BM_WIDTH = 4;
    localparam int BM_ITER  = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_CAPT = 3'd4;

endpackage

// File: rtl/iiitb_bm_op_fifo.sv
// Synchronous FIFO holding {m,q} operand pairs for the Booth sequencer.
module iiitb_bm_op_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // A write while full is accepted only when a read frees a slot in the same cycle.
    always_comb begin
        push = wr_en && (!full || rd_en);
        pop  = rd_en && !empty;
    end

    // Storage, pointers and occupancy; reset discards all contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/iiitb_r2_bm_seq_ctrl.sv
// Sequencer around the radix-2 4-bit Booth core: operand stream in,
// registered core controls, held product out on a valid/ready stream.
module iiitb_r2_bm_seq_ctrl
    import iiitb_bm_pkg::*;
#(
    parameter int WIDTH      = BM_WIDTH,
    parameter int ITER       = BM_ITER,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               mul_load,
    output logic               mul_reset,
    output logic [WIDTH-1:0]   mul_m,
    output logic [WIDTH-1:0]   mul_q,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               busy,
    output logic [7:0]         done_cnt
);

    localparam int RW = (ITER > 1) ? $clog2(ITER) : 1;

    logic [2:0]         state;
    logic [RW-1:0]      rcnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_wr;
    logic               fifo_rd;
    logic [2*WIDTH-1:0] fifo_head;

    assign in_ready = reset && !fifo_full;
    assign fifo_wr  = in_valid && in_ready;
    assign fifo_rd  = (state == ST_LOAD);
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    iiitb_bm_op_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_op_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data ({in_m, in_q}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sequencer FSM, registered core controls, result register and delivery count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rcnt      <= '0;
            mul_load  <= 1'b0;
            mul_reset <= 1'b1;
            mul_m     <= '0;
            mul_q     <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
            done_cnt  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                done_cnt  <= done_cnt + 8'd1;
            end
            case (state)
                ST_IDLE: begin
                    mul_reset <= 1'b1;
                    mul_load  <= 1'b0;
                    if (!fifo_empty) begin
                        state <= ST_CLR;
                    end
                end
                // Controls are registered, so the LOAD-cycle values are set on the CLR exit edge.
                ST_CLR: begin
                    mul_reset <= 1'b0;
                    mul_load  <= 1'b1;
                    mul_m     <= fifo_head[2*WIDTH-1:WIDTH];
                    mul_q     <= fifo_head[WIDTH-1:0];
                    state     <= ST_LOAD;
                end
                ST_LOAD: begin
                    mul_load <= 1'b0;
                    rcnt     <= RW'(ITER - 1);
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (rcnt == '0) begin
                        state <= ST_CAPT;
                    end else begin
                        rcnt <= rcnt - 1'b1;
                    end
                end
                ST_CAPT: begin
                    // Overrides the handshake clear above when both happen together.
                    if (!out_valid || out_ready) begin
                        out_p     <= mul_p;
                        out_valid <= 1'b1;
                        mul_reset <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    mul_reset <= 1'b1;
                    mul_load  <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iiitb_r2_bm_seq_ctrl.sv
// Directed self-checking bench for the Booth sequencer, with a behavioural
// radix-2 Booth core attached to the core-side pins.
module tb_iiitb_r2_bm_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_m = '0;
    logic [3:0] in_q = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_p;
    logic       mul_load;
    logic       mul_reset;
    logic [3:0] mul_m;
    logic [3:0] mul_q;
    logic [7:0] mul_p;
    logic       busy;
    logic [7:0] done_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iiitb_r2_bm_seq_ctrl #(
        .WIDTH      (4),
        .ITER       (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_m      (in_m),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .mul_load  (mul_load),
        .mul_reset (mul_reset),
        .mul_m     (mul_m),
        .mul_q     (mul_q),
        .mul_p     (mul_p),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    // Behavioural core: synchronous reset reloads Count, load only takes operands.
    logic [3:0] c_a, c_q, c_m, c_sum;
    logic       c_q1;
    logic [2:0] c_cnt;

    always_comb begin
        c_sum = c_a;
        case ({c_q[0], c_q1})
            2'b01:   c_sum = c_a + c_m;
            2'b10:   c_sum = c_a - c_m;
            default: c_sum = c_a;
        endcase
    end

    always @(posedge clk) begin
        if (mul_reset) begin
            c_a <= '0; c_q <= '0; c_m <= '0; c_q1 <= 1'b0; c_cnt <= 3'd4;
        end else if (mul_load) begin
            c_a <= '0; c_q <= mul_q; c_m <= mul_m; c_q1 <= 1'b0;
        end else if (c_cnt != 3'd0) begin
            c_a   <= {c_sum[3], c_sum[3:1]};
            c_q   <= {c_sum[0], c_q[3:1]};
            c_q1  <= c_q[0];
            c_cnt <= c_cnt - 3'd1;
        end
    end

    assign mul_p = {c_a, c_q};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got=timeout expected=event", tag);
    endtask

    // Offer a pair; returns #1 after the accepting edge.
    task automatic push(input logic [3:0] m, input logic [3:0] q);
        int t;
        @(negedge clk);
        in_valid = 1'b1; in_m = m; in_q = q;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) timeout("push");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for a product, check it, and let the handshake edge pass (out_ready must be 1).
    task automatic wait_out(input string tag, input logic [7:0] exp);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) timeout(tag);
        else chk(tag, 32'(out_p), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int lat;
        logic [7:0] p_seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_p", 32'(out_p), 0);
        chk("rst_mul_load", 32'(mul_load), 0);
        chk("rst_mul_reset", 32'(mul_reset), 1);
        chk("rst_mul_mq", 32'({mul_m, mul_q}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done_cnt", 32'(done_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Latency: 3*2
        out_ready = 1'b1;
        push(4'd3, 4'd2);
        lat = 0; p_seen = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid && lat == 0) begin
                lat = k;
                p_seen = out_p;
            end
        end
        chk("latency", 32'(lat), 8);
        chk("p_3x2", 32'(p_seen), 32'h06);

        push(4'hD, 4'd5);
        wait_out("p_m3x5", 8'hF1);
        push(4'd7, 4'h8);
        wait_out("p_7xm8", 8'hC8);
        chk("done_cnt_3", 32'(done_cnt), 3);

        // Backpressure: three pairs with out_ready low
        do_reset();
        out_ready = 1'b0;
        push(4'd1, 4'd1);
        push(4'd2, 4'd3);
        chk("fifo_full_in_ready", 32'(in_ready), 0);
        push(4'hE, 4'd3);
        repeat (30) @(posedge clk);
        #1;
        chk("held_valid", 32'(out_valid), 1);
        chk("held_p", 32'(out_p), 32'h01);
        chk("capt_stall_ctrl", 32'({mul_load, mul_reset}), 0);
        chk("capt_stall_busy", 32'(busy), 1);
        chk("capt_stall_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("same_cycle_valid", 32'(out_valid), 1);
        chk("same_cycle_p", 32'(out_p), 32'h06);
        @(posedge clk);
        #1;
        wait_out("bp_third", 8'hFA);
        chk("bp_done_cnt", 32'(done_cnt), 3);

        // Reset during RUN of 5*3
        push(4'd5, 4'd3);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_mul_reset", 32'(mul_reset), 1);
        @(negedge clk);
        reset = 1'b1;
        push(4'd2, 4'd2);
        wait_out("after_rst_2x2", 8'h04);

        // Sweep all pairs except M=-8, then pad to 256 deliveries for the wrap
        do_reset();
        out_ready = 1'b1;
        for (int mi = -7; mi <= 7; mi++) begin
            for (int qi = -8; qi <= 7; qi++) begin
                int e;
                logic [31:0] mv, qv;
                e  = mi * qi;
                mv = 32'(mi);
                qv = 32'(qi);
                push(mv[3:0], qv[3:0]);
                wait_out($sformatf("sweep_%0d_x_%0d", mi, qi), 8'(e));
            end
        end
        chk("done_cnt_240", 32'(done_cnt), 240);
        for (int k = 0; k < 16; k++) begin
            push(4'd1, 4'd1);
            wait_out("wrap_pad", 8'h01);
        end
        chk("done_cnt_wrap", 32'(done_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
